speaker_i2s_tx: RTL and testbench



---
 rtl/speaker_i2s_tx.sv | 239 +++++++++++++++++++++++
 tb/tb_speaker_i2s_tx.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/speaker_i2s_tx.sv
// speaker_i2s_tx
// ---------------------------------------------------------------------------
// Playback-side I2S master transmitter. Stereo sample words {left[31:16],
// right[15:0]} are pushed into a small FIFO and serialised MSB first toward
// the DAC with the standard one-bit I2S delay after each LRCK transition.
// BCLK and LRCK free-run from reset so the DAC stays locked; only the data
// content depends on the playback state.
//
// Optional build macro:
//   SPEAKER_UNDERRUN_HOLD_EN  - on an underrun load, re-send the last word
//                               popped since entering playback (0 if none)
//                               instead of silence.
//
// Parameters:
//   CLK_DIV  clk cycles per BCLK half-period (>= 1)
//   FIFO_AW  FIFO address width, depth = 2**FIFO_AW words
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   play_start   one-cycle pulse, enter playback
//   play_stop    one-cycle pulse, leave playback and flush the FIFO
//   in_data      {left, right} sample word
//   in_valid     in_data valid
//   in_ready     play_active & !fifo_full
//   bclk         I2S bit clock
//   lrck         I2S word select (0 = left)
//   sdata        I2S serial data, MSB first
//   play_active  playback state
//   underrun     one-cycle pulse: frame load found the FIFO empty while active
//   fifo_level   current FIFO word count
// ---------------------------------------------------------------------------
module speaker_i2s_tx #(
  parameter int CLK_DIV = 4,
  parameter int FIFO_AW = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               play_start,
  input  logic               play_stop,
  input  logic [31:0]        in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic               bclk,
  output logic               lrck,
  output logic               sdata,
  output logic               play_active,
  output logic               underrun,
  output logic [FIFO_AW:0]   fifo_level
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int LVL_W = FIFO_AW + 1;

  typedef enum logic {
    ST_IDLE,
    ST_PLAY
  } state_t;

  state_t             state_reg, state_next;
  logic [DIV_W-1:0]   div_cnt_reg;
  logic               bclk_reg;
  logic               lrck_reg;
  logic               sdata_reg;
  logic [4:0]         bit_cnt_reg;
  logic [31:0]        shift_reg;
  logic               underrun_reg;
  logic [FIFO_AW-1:0] wr_ptr_reg;
  logic [FIFO_AW-1:0] rd_ptr_reg;
  logic [LVL_W-1:0]   level_reg;
  logic [31:0]        mem_reg [DEPTH];

  logic        div_wrap;
  logic        fall_edge;
  logic        load_edge;
  logic [4:0]  bit_cnt_next;
  logic        fifo_full;
  logic        fifo_empty;
  logic        push;
  logic        load_live;
  logic        pop;
  logic        underrun_load;
  logic [31:0] head_word;
  logic [31:0] underrun_word;
  logic [31:0] load_word;

  // ---------------------------------------------------------------------
  // Playback state machine
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Stop has priority over a simultaneous start.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (play_start && !play_stop) state_next = ST_PLAY;
      ST_PLAY: if (play_stop)                state_next = ST_IDLE;
      default:                               state_next = ST_IDLE;
    endcase
  end

  assign play_active = (state_reg == ST_PLAY);

  // ---------------------------------------------------------------------
  // Bit clock timing
  // ---------------------------------------------------------------------
  assign div_wrap     = (div_cnt_reg == DIV_W'(CLK_DIV - 1));
  assign fall_edge    = div_wrap & bclk_reg;
  assign bit_cnt_next = bit_cnt_reg + 5'd1;
  // The word is loaded one BCLK after the LRCK transition (I2S delay).
  assign load_edge    = fall_edge & (bit_cnt_next == 5'd1);

  // ---------------------------------------------------------------------
  // FIFO control
  // ---------------------------------------------------------------------
  assign fifo_full  = (level_reg == LVL_W'(DEPTH));
  assign fifo_empty = (level_reg == '0);
  assign in_ready   = play_active & ~fifo_full;
  assign fifo_level = level_reg;

  // A flush cycle discards any push and suppresses the frame load, so the
  // stop always wins over whatever else happens in that cycle.
  assign push          = in_valid & in_ready & ~play_stop;
  assign load_live     = load_edge & play_active & ~play_stop;
  assign pop           = load_live & ~fifo_empty;
  assign underrun_load = load_live & fifo_empty;
  assign head_word     = mem_reg[rd_ptr_reg];

`ifdef SPEAKER_UNDERRUN_HOLD_EN
  logic [31:0] last_word_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_word_reg <= '0;
    end else if (play_stop) begin
      last_word_reg <= '0;
    end else if (pop) begin
      last_word_reg <= head_word;
    end
  end

  assign underrun_word = last_word_reg;
`else
  assign underrun_word = '0;
`endif

  always_comb begin
    load_word = '0;
    if (pop) begin
      load_word = head_word;
    end else if (underrun_load) begin
      load_word = underrun_word;
    end
  end

  // Sample storage: plain array so it maps onto distributed RAM; the head
  // word must be available in the load cycle itself.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_reg[wr_ptr_reg] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else if (play_stop) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + FIFO_AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + FIFO_AW'(1);
      case ({push, pop})
        2'b10:   level_reg <= level_reg + LVL_W'(1);
        2'b01:   level_reg <= level_reg - LVL_W'(1);
        default: level_reg <= level_reg;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Serialiser: everything visible to the DAC changes on BCLK falls only
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_reg  <= '0;
      bclk_reg     <= 1'b0;
      lrck_reg     <= 1'b1;
      sdata_reg    <= 1'b0;
      bit_cnt_reg  <= 5'd31;
      shift_reg    <= '0;
      underrun_reg <= 1'b0;
    end else begin
      underrun_reg <= 1'b0;

      if (div_wrap) begin
        div_cnt_reg <= '0;
        bclk_reg    <= ~bclk_reg;
      end else begin
        div_cnt_reg <= div_cnt_reg + DIV_W'(1);
      end

      if (fall_edge) begin
        bit_cnt_reg <= bit_cnt_next;
        // Upper half of the 32-bit frame is the right channel.
        lrck_reg    <= bit_cnt_next[4];
        if (load_edge) begin
          sdata_reg    <= load_word[31];
          shift_reg    <= {load_word[30:0], 1'b0};
          underrun_reg <= underrun_load;
        end else begin
          sdata_reg <= shift_reg[31];
          shift_reg <= {shift_reg[30:0], 1'b0};
        end
      end

      // Remaining bits of the current word are dropped on stop.
      if (play_stop) begin
        shift_reg <= '0;
      end
    end
  end

  assign bclk     = bclk_reg;
  assign lrck     = lrck_reg;
  assign sdata    = sdata_reg;
  assign underrun = underrun_reg;

endmodule

// File: tb/tb_speaker_i2s_tx.sv
// Testbench for speaker_i2s_tx (CLK_DIV = 2, FIFO_AW = 2).
// A frame-level reference model derives BCLK/LRCK from the elapsed clock
// count, keeps the FIFO as a queue and picks the frame word at every load
// point; all DUT outputs are compared against it on every falling clk edge.
module tb_speaker_i2s_tx;

  localparam int CD    = 2;
  localparam int AW    = 2;
  localparam int DEPTH = 1 << AW;
  localparam int FRAME = 64 * CD;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          play_start = 1'b0;
  logic          play_stop = 1'b0;
  logic [31:0]   in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          bclk;
  logic          lrck;
  logic          sdata;
  logic          play_active;
  logic          underrun;
  logic [AW:0]   fifo_level;

  always #5 clk = ~clk;

  speaker_i2s_tx #(.CLK_DIV(CD), .FIFO_AW(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .play_start (play_start),
    .play_stop  (play_stop),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .bclk       (bclk),
    .lrck       (lrck),
    .sdata      (sdata),
    .play_active(play_active),
    .underrun   (underrun),
    .fifo_level (fifo_level)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // ---------------- reference model state ----------------
  int          n;            // clk edges since reset release
  bit          m_active;
  logic [31:0] m_q[$];
  logic [31:0] m_cur;        // word being shifted out this frame
  logic [31:0] m_last;       // last popped word since entering playback
  logic        m_sdata;
  logic        m_underrun;
  bit          m_pushed;
  bit          m_popped;

  // serial capture
  bit          cap_arm = 1'b0;
  int          cap_left = 0;
  logic [31:0] cap_word = '0;
  logic        prev_bclk = 1'b0;

  typedef struct {
    logic [31:0] word;
    logic [15:0] exp_left;
    logic [15:0] exp_right;
  } vec_t;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic m_bclk();
    return ((n / CD) % 2) == 1;
  endfunction

  function automatic logic m_lrck();
    int k;
    k = n / (2 * CD);
    if (k == 0) return 1'b1;
    return ((k - 1) % 32) >= 16;
  endfunction

  // next clock edge is the fall that starts bit 1 (frame word load)
  function automatic bit load_next();
    int n1;
    n1 = n + 1;
    return (n1 % (2 * CD) == 0) && (((n1 / (2 * CD)) - 1) % 32 == 1);
  endfunction

  task automatic model_reset();
    n = 0;
    m_active = 1'b0;
    m_q.delete();
    m_cur = '0;
    m_last = '0;
    m_sdata = 1'b0;
    m_underrun = 1'b0;
    m_pushed = 1'b0;
    m_popped = 1'b0;
  endtask

  task automatic model_step();
    bit stop, start, push_ok;
    int k, b;
    stop  = play_stop;
    start = play_start;
    push_ok = in_valid && m_active && (m_q.size() < DEPTH) && !stop;
    m_pushed = push_ok;
    m_popped = 1'b0;
    m_underrun = 1'b0;
    n++;
    if (n % (2 * CD) == 0) begin
      k = n / (2 * CD);
      b = (k - 1) % 32;
      if (b == 1) begin
        if (m_active && !stop) begin
          if (m_q.size() > 0) begin
            m_cur = m_q.pop_front();
            m_last = m_cur;
            m_popped = 1'b1;
          end else begin
            m_underrun = 1'b1;
`ifdef SPEAKER_UNDERRUN_HOLD_EN
            m_cur = m_last;
`else
            m_cur = '0;
`endif
          end
        end else begin
          m_cur = '0;
        end
      end
      // bit b of the frame carries word bit (32-b) mod 32
      m_sdata = m_cur[(32 - b) % 32];
    end
    if (push_ok) m_q.push_back(in_data);
    if (stop) begin
      m_active = 1'b0;
      m_q.delete();
      m_cur = '0;
      m_last = '0;
    end else if (start) begin
      m_active = 1'b1;
    end
  endtask

  task automatic compare_all();
    check("bclk", 32'(bclk), 32'(m_bclk()));
    check("lrck", 32'(lrck), 32'(m_lrck()));
    check("sdata", 32'(sdata), 32'(m_sdata));
    check("play_active", 32'(play_active), 32'(m_active));
    check("underrun", 32'(underrun), 32'(m_underrun));
    check("fifo_level", 32'(fifo_level), 32'(m_q.size()));
    check("in_ready", 32'(in_ready), 32'(m_active && (m_q.size() < DEPTH)));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    cyc++;
    compare_all();
    if (cap_left > 0 && !prev_bclk && bclk) begin
      cap_word = {cap_word[30:0], sdata};
      cap_left--;
    end
    if (cap_arm && m_popped) begin
      cap_left = 32;
      cap_arm = 1'b0;
    end
    prev_bclk = bclk;
    play_start = 1'b0;
    play_stop = 1'b0;
  endtask

  task automatic apply_reset(int hold);
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    repeat (hold) begin
      @(negedge clk);
      compare_all();
    end
    rst_n = 1'b1;
    prev_bclk = 1'b0;
    in_valid = 1'b0;
    play_start = 1'b0;
    play_stop = 1'b0;
  endtask

  task automatic safe_stop();
    while (load_next()) cycle();
    play_stop = 1'b1;
    cycle();
  endtask

  task automatic measure_first_fall(string name);
    int c;
    c = 0;
    do begin
      cycle();
      c++;
    end while (lrck !== 1'b0 && c < 200);
    check(name, c, 2 * CD);
  endtask

  task automatic push_words(int count, string name);
    int got, guard;
    got = 0;
    guard = 0;
    while (got < count && guard < 600) begin
      in_valid = 1'b1;
      in_data = $urandom();
      cycle();
      if (m_pushed) got++;
      guard++;
    end
    in_valid = 1'b0;
    check(name, got, count);
  endtask

  task automatic wait_underrun(string name);
    int guard;
    guard = 0;
    do begin
      cycle();
      guard++;
    end while (!m_underrun && guard < 300);
    check(name, 32'(m_underrun), 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t vecs[4];
    int c, cnt, idx, guard, stalled;
    bit seen_high, done;

    vecs[0] = '{32'h5A5AA5A5, 16'h5A5A, 16'hA5A5};
    vecs[1] = '{32'hFFFF0001, 16'hFFFF, 16'h0001};
    vecs[2] = '{32'h80000001, 16'h8000, 16'h0001};
    vecs[3] = '{32'h12345678, 16'h1234, 16'h5678};

    // ---- reset and free-running timing ----
    @(negedge clk);
    apply_reset(3);
    measure_first_fall("first_lrck_fall");
    c = 0;
    seen_high = 1'b0;
    while (c < 400) begin
      cycle();
      c++;
      if (lrck === 1'b1) seen_high = 1'b1;
      if (seen_high && lrck === 1'b0) break;
    end
    check("lrck_period", c, FRAME);
    cnt = 0;
    repeat (2 * FRAME) begin
      cycle();
      if (underrun === 1'b1) cnt++;
    end
    check("idle_underrun_count", cnt, 0);

    // ---- table-driven single-word frames ----
    for (int i = 0; i < 4; i++) begin
      safe_stop();
      play_start = 1'b1;
      cycle();
      in_valid = 1'b1;
      in_data = vecs[i].word;
      cap_arm = 1'b1;
      cycle();
      in_valid = 1'b0;
      guard = 0;
      while ((cap_arm || cap_left > 0) && guard < 400) begin
        cycle();
        guard++;
      end
      done = !cap_arm && cap_left == 0;
      check("tbl_frame_done", 32'(done), 1);
      check("tbl_serial_word", cap_word, {vecs[i].exp_left, vecs[i].exp_right});
    end

    // ---- five pushes into a four-deep FIFO ----
    safe_stop();
    play_start = 1'b1;
    cycle();
    wait_underrun("push5_sync");
    idx = 0;
    guard = 0;
    stalled = 0;
    while (idx < 5 && guard < 600) begin
      in_valid = 1'b1;
      in_data = 32'h1000_0000 + idx;
      if (!in_ready) stalled++;
      cycle();
      if (m_pushed) idx++;
      guard++;
    end
    in_valid = 1'b0;
    check("push5_accepted", idx, 5);
    check("push5_backpressure", 32'(stalled > 0), 1);
    repeat (6 * FRAME) cycle();

    // ---- underrun with empty FIFO ----
    safe_stop();
    play_start = 1'b1;
    cycle();
    in_valid = 1'b1;
    in_data = 32'hFFFF0001;
    cycle();
    in_valid = 1'b0;
    guard = 0;
    while (!m_popped && guard < 300) begin
      cycle();
      guard++;
    end
    check("underrun_first_pop", 32'(m_popped), 1);
    cnt = 0;
    repeat (2 * FRAME) begin
      cycle();
      if (underrun === 1'b1) cnt++;
    end
    check("underrun_count", cnt, 2);

    // ---- flush with a push in the stop cycle ----
    safe_stop();
    play_start = 1'b1;
    cycle();
    push_words(3, "flush_prefill");
    while (load_next()) cycle();
    in_valid = 1'b1;
    in_data = 32'hDEADBEEF;
    play_stop = 1'b1;
    cycle();
    in_valid = 1'b0;
    check("flush_level", 32'(fifo_level), 0);
    check("flush_in_ready", 32'(in_ready), 0);
    check("flush_active", 32'(play_active), 0);
    repeat (2 * FRAME) cycle();
    play_start = 1'b1;
    play_stop = 1'b1;
    cycle();
    check("start_stop_same_cycle", 32'(play_active), 0);
    repeat (10) cycle();

    // ---- randomized traffic ----
    for (int i = 0; i < 3000; i++) begin
      play_start = ($urandom_range(0, 39) == 0);
      play_stop  = ($urandom_range(0, 59) == 0) && !load_next();
      in_valid   = ($urandom_range(0, 9) < 6);
      in_data    = $urandom();
      cycle();
    end
    in_valid = 1'b0;

    // ---- asynchronous reset mid-frame at bit 9 ----
    safe_stop();
    play_start = 1'b1;
    cycle();
    wait_underrun("reset_sync");
    push_words(2, "reset_prefill");
    guard = 0;
    while (!((n % (2 * CD) == CD) && (n >= 2 * CD) &&
             (((n / (2 * CD)) - 1) % 32 == 9)) && guard < 300) begin
      cycle();
      guard++;
    end
    check("reset_reached_bit9", 32'(((n / (2 * CD)) - 1) % 32), 9);
    apply_reset(2);
    measure_first_fall("post_reset_lrck_fall");
    repeat (FRAME) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
